// File: rtl/draw_command_sequencer_if.sv
// Command/strobe bundle between the frame sequencer (master) and its frame-control peer.
// The master drives the command stream and status pulses. The peer drives the frame tick and block mask.
interface draw_command_sequencer_if #(
    parameter int NUM_BLOCKS = 15
);
    logic                  frame_tick;
    logic [NUM_BLOCKS-1:0] block_valid;
    logic [4:0]            command;
    logic                  plot;
    logic                  busy;
    logic                  frame_done;
    logic                  frame_overrun;

    modport master (
        input  frame_tick, block_valid,
        output command, plot, busy, frame_done, frame_overrun
    );

    modport slave (
        output frame_tick, block_valid,
        input  command, plot, busy, frame_done, frame_overrun
    );
endinterface

// File: rtl/draw_command_sequencer.sv
// Per-frame command stream: full clear, then one window per enabled note block. All outputs are registered.
// There is no backpressure. A frame_tick that arrives while busy is dropped and flagged on frame_overrun.
module draw_command_sequencer #(
    parameter int NUM_BLOCKS   = 15,
    parameter int BLOCK_CYCLES = 16,
    parameter int CLEAR_CYCLES = 19764
) (
    input  logic                    CLK,
    input  logic                    reset,
    draw_command_sequencer_if.master cmd_if
);
    localparam int CNT_W = $clog2(CLEAR_CYCLES);
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [NUM_BLOCKS-1:0] mask_q;
    logic [IDX_W-1:0]      idx_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [4:0]            command_q;
    logic                  plot_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic                  frame_overrun_q;

    logic                  blk_en;
    logic                  clear_last;
    logic                  block_last;
    logic                  idx_last;

    assign blk_en     = mask_q[idx_q];
    assign clear_last = (cnt_q == CNT_W'(CLEAR_CYCLES - 1));
    assign block_last = (cnt_q == CNT_W'(BLOCK_CYCLES - 1));
    assign idx_last   = (idx_q == IDX_W'(NUM_BLOCKS - 1));

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q         <= S_IDLE;
            mask_q          <= '0;
            idx_q           <= '0;
            cnt_q           <= '0;
            command_q       <= 5'b0_1111;
            plot_q          <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_overrun_q <= 1'b0;
        end else begin
            frame_done_q    <= 1'b0;
            frame_overrun_q <= cmd_if.frame_tick && (state_q != S_IDLE);
            // The processor registers its pixel output, so plot trails the plotting cycle by one.
            plot_q          <= (state_q == S_CLEAR) || ((state_q == S_DRAW) && blk_en);

            case (state_q)
                S_IDLE: begin
                    if (cmd_if.frame_tick) begin
                        state_q   <= S_CLEAR;
                        mask_q    <= cmd_if.block_valid;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        command_q <= 5'b1_1111;
                        busy_q    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clear_last) begin
                        state_q   <= S_DRAW;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        command_q <= {1'b1, IDX_W'(0)};
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DRAW: begin
                    // A disabled block costs a single skip cycle; an enabled one holds for its full window.
                    if (blk_en && !block_last) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (idx_last) begin
                        state_q      <= S_DONE;
                        cnt_q        <= '0;
                        command_q    <= 5'b0_1111;
                        frame_done_q <= 1'b1;
                    end else begin
                        idx_q     <= idx_q + IDX_W'(1);
                        cnt_q     <= '0;
                        command_q <= {1'b1, idx_q + IDX_W'(1)};
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    command_q <= 5'b0_1111;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    command_q <= 5'b0_1111;
                end
            endcase
        end
    end

    assign cmd_if.command       = command_q;
    assign cmd_if.plot          = plot_q;
    assign cmd_if.busy          = busy_q;
    assign cmd_if.frame_done    = frame_done_q;
    assign cmd_if.frame_overrun = frame_overrun_q;
endmodule
